// File: rtl/shared_unit_arbiter_if.sv
// Bundles the requester, resource and response signals of the shared-unit arbiter.
// The arbiter uses the slave view; whoever drives requests and models the resource uses the master view.
interface shared_unit_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req;
    logic [DATA_W-1:0] req_data_1;
    logic [DATA_W-1:0] req_data_2;
    logic              flush_1;
    logic              flush_2;
    logic              res_start;
    logic [DATA_W-1:0] res_operand;
    logic              res_done;
    logic [DATA_W-1:0] res_result;
    logic              stall_1;
    logic              stall_2;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              owner;
    logic              busy;
    logic              err_timeout;

    modport slave (
        input  req, req_data_1, req_data_2, flush_1, flush_2, res_done, res_result,
        output res_start, res_operand, stall_1, stall_2, rsp_valid, rsp_data,
               owner, busy, err_timeout
    );

    modport master (
        output req, req_data_1, req_data_2, flush_1, flush_2, res_done, res_result,
        input  res_start, res_operand, stall_1, stall_2, rsp_valid, rsp_data,
               owner, busy, err_timeout
    );
endinterface

// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle resource between two pipelines, with flush and timeout abort.
//   state   | meaning
//   S_IDLE  | no transaction; pick an eligible requester
//   S_ISSUE | start pulse to the resource, operand latched
//   S_WAIT  | waiting for res_done, timeout counter running
//   S_RESP  | deliver result to owner unless cancelled
module shared_unit_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input logic                  clk,
    input logic                  reset,
    shared_unit_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              owner_q;
    logic              rr_last;
    logic              cancel;
    logic [TO_W-1:0]   cnt;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_q;

    logic [1:0] eligible;
    logic       grant_id;
    logic       flush_owner;
    logic       timeout_hit;
    logic [1:0] rsp_valid_w;

    assign eligible    = bus.req & ~{bus.flush_2, bus.flush_1};
    assign flush_owner = owner_q ? bus.flush_2 : bus.flush_1;
    assign timeout_hit = (cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        grant_id  = 1'b0;
        case (state)
            S_IDLE: begin
                grant_id = (eligible == 2'b11) ? ~rr_last : eligible[1];
                if (|eligible) state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (bus.res_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            owner_q    <= 1'b0;
            rr_last    <= 1'b1;
            cancel     <= 1'b0;
            cnt        <= '0;
            operand_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|eligible) begin
                        owner_q   <= grant_id;
                        operand_q <= grant_id ? bus.req_data_2 : bus.req_data_1;
                        cnt       <= '0;
                        cancel    <= 1'b0;
                    end
                end
                S_ISSUE: if (flush_owner) cancel <= 1'b1;
                S_WAIT: begin
                    cnt <= cnt + TO_W'(1);
                    if (flush_owner) cancel <= 1'b1;
                    // a flush landing in the same cycle as res_done still discards the result
                    if (bus.res_done) begin
                        if (!(cancel || flush_owner)) rsp_data_q <= bus.res_result;
                    end else if (timeout_hit) begin
                        err_q  <= 1'b1;
                        cancel <= 1'b1;
                    end
                end
                S_RESP: if (!cancel) rr_last <= owner_q;
                default: ;
            endcase
        end
    end

    assign rsp_valid_w     = (state == S_RESP && !cancel) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    assign bus.res_start   = (state == S_ISSUE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.rsp_valid   = rsp_valid_w;
    assign bus.res_operand = operand_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.owner       = owner_q;
    assign bus.err_timeout = err_q;
    assign bus.stall_1     = bus.req[0] & ~rsp_valid_w[0] & ~bus.flush_1;
    assign bus.stall_2     = bus.req[1] & ~rsp_valid_w[1] & ~bus.flush_2;
endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Randomized bench for shared_unit_arbiter, checked against a transaction-level timing model.
module tb_shared_unit_arbiter;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic              m_rr_last;
    logic [DATA_W-1:0] m_rsp_data;

    shared_unit_arbiter_if #(.DATA_W(DATA_W)) bus ();

    shared_unit_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, need finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [31:0] d1, input logic [31:0] d2,
                         input logic f1, input logic f2, input logic done, input logic [31:0] res);
        bus.req        = r;
        bus.req_data_1 = d1;
        bus.req_data_2 = d2;
        bus.flush_1    = f1;
        bus.flush_2    = f2;
        bus.res_done   = done;
        bus.res_result = res;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_start"}, 32'(bus.res_start), 0);
        chk({tag, "_rv"},    32'(bus.rsp_valid), 0);
        chk({tag, "_own"},   32'(bus.owner), 0);
        chk({tag, "_err"},   32'(bus.err_timeout), 0);
        chk({tag, "_op"},    bus.res_operand, 0);
        chk({tag, "_rd"},    bus.rsp_data, 0);
    endtask

    // One request-to-response transaction.
    // mode 0 plain, 1 flush owner once in ISSUE/WAIT, 2 flush non-owner throughout, 3 owner drops req.
    // d: res_done arrives d cycles after res_start; d > TIMEOUT means never (timeout abort).
    task automatic txn(input logic [1:0] r, input int d, input int mode, input logic spur,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] res);
        logic [1:0] reqv;
        logic [1:0] exp_rv;
        logic       f1, f2, done;
        int         w, e, fc;
        bit         tmo, canc;
        w    = (r == 2'b11) ? (m_rr_last ? 0 : 1) : (r[1] ? 1 : 0);
        tmo  = d > TIMEOUT;
        e    = tmo ? TIMEOUT + 2 : d + 2;
        fc   = (mode == 1) ? int'($urandom_range(1, e - 1)) : 0;
        canc = tmo || (mode == 1);
        reqv = r;

        @(negedge clk);
        drive(reqv, d1, d2, 1'b0, 1'b0, spur, $urandom);
        #1;
        chk("idle_busy",  32'(bus.busy), 0);
        chk("idle_start", 32'(bus.res_start), 0);
        chk("idle_rv",    32'(bus.rsp_valid), 0);
        chk("idle_st1",   32'(bus.stall_1), 32'(r[0]));
        chk("idle_st2",   32'(bus.stall_2), 32'(r[1]));

        for (int c = 1; c <= e; c++) begin
            @(negedge clk);
            if (mode == 3 && c >= 2) reqv[w] = 1'b0;
            if (mode == 1 && c > fc) reqv[w] = 1'b0;
            f1   = (mode == 1 && c == fc && w == 0) || (mode == 2 && w == 1);
            f2   = (mode == 1 && c == fc && w == 1) || (mode == 2 && w == 0);
            done = (!tmo && c == d + 1) || (spur && (c == 1 || c == e));
            drive(reqv, $urandom, $urandom, f1, f2, done, (c == d + 1) ? res : $urandom);
            #1;
            exp_rv = (c == e && !canc) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("start", 32'(bus.res_start), 32'(c == 1));
            chk("busy",  32'(bus.busy), 1);
            chk("owner", 32'(bus.owner), 32'(w));
            chk("oper",  bus.res_operand, (w == 1) ? d2 : d1);
            chk("rv",    32'(bus.rsp_valid), 32'(exp_rv));
            chk("err",   32'(bus.err_timeout), 32'(c == e && tmo));
            chk("st1",   32'(bus.stall_1), 32'(reqv[0] & ~exp_rv[0] & ~f1));
            chk("st2",   32'(bus.stall_2), 32'(reqv[1] & ~exp_rv[1] & ~f2));
            if (c == e) begin
                if (!canc) m_rsp_data = res;
                chk("rdata", bus.rsp_data, m_rsp_data);
            end
        end
        if (!canc) m_rr_last = (w == 1);
    endtask

    // Request and flush together in IDLE: the request must be ignored.
    task automatic flush_idle(input logic [1:0] r);
        @(negedge clk);
        drive(r, $urandom, $urandom, r[0], r[1], 1'b0, $urandom);
        #1;
        chk("fi_busy", 32'(bus.busy), 0);
        chk("fi_st1",  32'(bus.stall_1), 0);
        chk("fi_st2",  32'(bus.stall_2), 0);
    endtask

    initial begin
        int d, mode;
        logic [1:0] r;
        n_checks   = 0;
        n_errors   = 0;
        m_rr_last  = 1'b1;
        m_rsp_data = '0;
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_regs_zero("rst");
        reset = 1'b1;
        @(negedge clk);
        #1 chk_regs_zero("post_rst");

        txn(2'b01, 2, 0, 1'b0, 32'h11, 32'h0, 32'h22);
        for (int i = 0; i < 4; i++) txn(2'b11, 1, 0, 1'b0, $urandom, $urandom, $urandom);
        txn(2'b10, 5, 1, 1'b0, $urandom, $urandom, 32'hDEAD);
        txn(2'b11, 3, 0, 1'b0, $urandom, $urandom, $urandom);
        txn(2'b01, TIMEOUT + 4, 0, 1'b0, $urandom, $urandom, $urandom);
        txn(2'b10, TIMEOUT, 0, 1'b1, $urandom, $urandom, $urandom);
        flush_idle(2'b11);
        txn(2'b11, 2, 3, 1'b0, $urandom, $urandom, $urandom);

        for (int i = 0; i < 150; i++) begin
            r    = 2'($urandom_range(1, 3));
            d    = ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : int'($urandom_range(1, TIMEOUT));
            mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) flush_idle(r);
            txn(r, d, mode, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
        end

        // reset in the middle of WAIT, then a late res_done
        @(negedge clk);
        drive(2'b01, 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        #1 chk("mid_busy", 32'(bus.busy), 1);
        #2 reset = 1'b0;
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        #1 chk_regs_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 32'hBEEF);
        @(negedge clk);
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        #1 chk_regs_zero("late_done");
        m_rr_last  = 1'b1;
        m_rsp_data = '0;
        txn(2'b11, 2, 0, 1'b0, $urandom, $urandom, $urandom);
        txn(2'b11, 4, 0, 1'b0, $urandom, $urandom, $urandom);

        @(negedge clk);
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
